// File: rtl/vend_pkg.sv
// Shared definitions for the coin vending payout path.
//  - CHG_0..CHG_3 : change codes (number of unit coins to return), shared
//                   with the vending FSM that issues payout requests.
//  - pay_state_e  : payout sequencer state encoding.
package vend_pkg;
  localparam logic [1:0] CHG_0 = 2'b00;
  localparam logic [1:0] CHG_1 = 2'b01;
  localparam logic [1:0] CHG_2 = 2'b10;
  localparam logic [1:0] CHG_3 = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PROD  = 3'd1,
    COIN  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4,
    FAULT = 3'd5
  } pay_state_e;
endpackage

// File: rtl/change_dispenser_if.sv
// Payout request handshake between the vending FSM (master) and the
// change dispenser (slave).
//  req_valid  : request present, held by the master until it sees req_ready
//  req_vend   : 1 = release one product
//  req_change : change code, number of unit coins to return
//  req_ready  : dispenser idle; request taken when req_valid && req_ready
interface change_dispenser_if;
  logic       req_valid;
  logic       req_vend;
  logic [1:0] req_change;
  logic       req_ready;

  modport master (output req_valid, req_vend, req_change, input req_ready);
  modport slave  (input req_valid, req_vend, req_change, output req_ready);
endinterface

// File: rtl/sense_sync.sv
// Optical sensor front end: 2-FF synchronizer followed by a rising-edge
// detector with a registered output. A held-high level yields one pulse.
//  clk  : system clock
//  rst  : asynchronous active-low reset
//  din  : raw asynchronous sensor level
//  rise : one-cycle pulse, high in the third cycle after din rises
module sense_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);
  // sh[1:0] is the synchronizer, sh[2] the previous synchronized level
  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh   <= '0;
      rise <= 1'b0;
    end else begin
      sh   <= {sh[1:0], din};
      rise <= sh[1] & ~sh[2];
    end
  end
endmodule

// File: rtl/change_dispenser.sv
// Payout sequencer: takes one request (product + up to 3 coins), drives the
// product solenoid first and then the coin ejector once per coin, each
// confirmed by its sensor. An unanswered actuation times out, waits a gap
// and retries; MAX_RETRY timeouts on one item latch FAULT until fault_clr.
//  clk, rst          : clock, asynchronous active-low reset
//  req               : request handshake (slave side)
//  prod_release/sense: product solenoid drive / drop sensor
//  coin_eject/sense  : hopper ejector drive / coin-exit sensor
//  done              : one-cycle pulse, request fully paid out
//  fault, fault_clr  : sticky fault flag / clear
//  coins_owed, vend_owed : unpaid items, valid while fault=1
module change_dispenser
  import vend_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000,
  parameter int GAP_CYC     = 50,
  parameter int MAX_RETRY   = 3
) (
  input  logic                clk,
  input  logic                rst,
  change_dispenser_if.slave   req,
  output logic                prod_release,
  input  logic                prod_sense,
  output logic                coin_eject,
  input  logic                coin_sense,
  output logic                done,
  output logic                fault,
  input  logic                fault_clr,
  output logic [1:0]          coins_owed,
  output logic                vend_owed
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYC - 1);
  localparam logic [2:0]    R_MAX  = 3'(MAX_RETRY);

  pay_state_e    state, state_nx;
  logic          vend_pend, vend_nx;
  logic [1:0]    cnt, cnt_nx;
  logic [2:0]    retry, retry_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [GW-1:0] gap, gap_nx;
  logic          rdy_q;

  // bit 0 = product sensor, bit 1 = coin sensor
  logic [1:0] sense_vec, hit;
  assign sense_vec = {coin_sense, prod_sense};

  for (genvar i = 0; i < 2; i++) begin : g_sync
    sense_sync u_sync (.clk(clk), .rst(rst), .din(sense_vec[i]), .rise(hit[i]));
  end

  logic       tmo;
  logic [2:0] retry_inc;
  assign tmo       = (timer == T_LAST);
  assign retry_inc = retry + 3'd1;

  always_comb begin
    state_nx = state;
    vend_nx  = vend_pend;
    cnt_nx   = cnt;
    retry_nx = retry;
    timer_nx = timer;
    gap_nx   = '0;
    case (state)
      IDLE: if (req.req_valid) begin
        vend_nx  = req.req_vend;
        cnt_nx   = req.req_change;
        retry_nx = '0;
        timer_nx = '0;
        state_nx = req.req_vend ? PROD : (req.req_change != CHG_0) ? COIN : DONE;
      end
      PROD: if (hit[0]) begin
        // edge beats a simultaneous timeout
        vend_nx  = 1'b0;
        retry_nx = '0;
        state_nx = (cnt != CHG_0) ? GAP : DONE;
      end else if (tmo) begin
        retry_nx = retry_inc;
        state_nx = (retry_inc == R_MAX) ? FAULT : GAP;
      end else begin
        timer_nx = timer + 1'b1;
      end
      COIN: if (hit[1]) begin
        cnt_nx   = cnt - 2'd1;
        retry_nx = '0;
        state_nx = (cnt != CHG_1) ? GAP : DONE;
      end else if (tmo) begin
        retry_nx = retry_inc;
        state_nx = (retry_inc == R_MAX) ? FAULT : GAP;
      end else begin
        timer_nx = timer + 1'b1;
      end
      GAP: begin
        timer_nx = '0;
        if (gap == G_LAST)
          state_nx = vend_pend ? PROD : (cnt != CHG_0) ? COIN : DONE;
        else
          gap_nx = gap + 1'b1;
      end
      DONE: state_nx = IDLE;
      FAULT: if (fault_clr) begin
        state_nx = IDLE;
        cnt_nx   = '0;
        vend_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      vend_pend <= 1'b0;
      cnt <= '0;
      retry <= '0;
      timer <= '0;
      gap <= '0;
    end else begin
      state <= state_nx;
      vend_pend <= vend_nx;
      cnt <= cnt_nx;
      retry <= retry_nx;
      timer <= timer_nx;
      gap <= gap_nx;
    end
  end

  // Outputs decoded from next state so they are registered yet line up
  // with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q        <= 1'b1;
      prod_release <= 1'b0;
      coin_eject   <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      coins_owed   <= '0;
      vend_owed    <= 1'b0;
    end else begin
      rdy_q        <= (state_nx == IDLE);
      prod_release <= (state_nx == PROD);
      coin_eject   <= (state_nx == COIN);
      done         <= (state_nx == DONE);
      fault        <= (state_nx == FAULT);
      coins_owed   <= (state_nx == FAULT) ? cnt_nx : 2'b00;
      vend_owed    <= (state_nx == FAULT) & vend_nx;
    end
  end

  assign req.req_ready = rdy_q;
endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
  localparam int T = 40;
  localparam int G = 8;
  localparam int R = 3;

  logic clk, rst, fault_clr;
  logic prod_release, coin_eject, done, fault, vend_owed;
  logic [1:0] coins_owed;
  logic resp_prod, resp_coin, spur_coin;
  logic prod_sense, coin_sense;

  change_dispenser_if ifc();

  assign prod_sense = resp_prod;
  assign coin_sense = resp_coin | spur_coin;

  change_dispenser #(.TIMEOUT_CYC(T), .GAP_CYC(G), .MAX_RETRY(R)) dut (
    .clk(clk), .rst(rst), .req(ifc.slave),
    .prod_release(prod_release), .prod_sense(prod_sense),
    .coin_eject(coin_eject), .coin_sense(coin_sense),
    .done(done), .fault(fault), .fault_clr(fault_clr),
    .coins_owed(coins_owed), .vend_owed(vend_owed));

  initial clk = 0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  // sensor responder plans: one entry per actuation, 0 = stay silent,
  // otherwise the number of cycles until the sensor pulses
  int prod_plan[$], coin_plan[$];

  // monitor state
  int n_prod = 0, n_coin = 0, n_done = 0, n_acc = 0;
  int prod_run = 0, coin_run = 0, gap_run = 0;
  bit prod_d = 0, coin_d = 0, gap_on = 0, act, act_d;
  int coin_len[$], prod_len[$], gap_len[$];

  always @(posedge clk) if (ifc.req_valid && ifc.req_ready) n_acc++;

  always @(negedge clk) begin
    if (prod_release && !prod_d) n_prod++;
    if (coin_eject && !coin_d) n_coin++;
    if (done) n_done++;
    if (coin_eject) coin_run++;
    else if (coin_d) begin coin_len.push_back(coin_run); coin_run = 0; end
    if (prod_release) prod_run++;
    else if (prod_d) begin prod_len.push_back(prod_run); prod_run = 0; end
    act   = prod_release | coin_eject;
    act_d = prod_d | coin_d;
    if (act && !act_d && gap_on) begin gap_len.push_back(gap_run); gap_on = 0; end
    else if (!act && act_d) begin gap_on = 1; gap_run = 1; end
    else if (!act && gap_on) gap_run++;
    if (done || fault || !rst) gap_on = 0;
    prod_d = prod_release;
    coin_d = coin_eject;
  end

  initial begin : resp_p
    bit d; int dly;
    d = 0; resp_prod = 0;
    forever begin
      @(negedge clk);
      if (prod_release && !d) begin
        dly = (prod_plan.size() > 0) ? prod_plan.pop_front() : 0;
        if (dly > 0) begin
          repeat (dly) @(negedge clk);
          resp_prod = 1; repeat (2) @(negedge clk); resp_prod = 0;
        end
      end
      d = prod_release;
    end
  end

  initial begin : resp_c
    bit d; int dly;
    d = 0; resp_coin = 0;
    forever begin
      @(negedge clk);
      if (coin_eject && !d) begin
        dly = (coin_plan.size() > 0) ? coin_plan.pop_front() : 0;
        if (dly > 0) begin
          repeat (dly) @(negedge clk);
          resp_coin = 1; repeat (2) @(negedge clk); resp_coin = 0;
        end
      end
      d = coin_eject;
    end
  end

  // Reference: walk the items product-first, one plan entry per actuation,
  // MAX_RETRY silent tries on one item is a fault.
  task automatic model(input bit vend, input int chg, input int pp[$], input int cp[$],
                       output int e_prod, output int e_coin, output bit e_fault,
                       output int e_owed_c, output bit e_owed_v);
    int paid, tries, k; bit ok;
    e_prod = 0; e_coin = 0; e_fault = 0; e_owed_c = 0; e_owed_v = 0;
    if (vend) begin
      tries = 0; ok = 0; k = 0;
      while (!ok && !e_fault) begin
        e_prod++;
        if (k < pp.size() && pp[k] > 0) ok = 1;
        else begin tries++; if (tries == R) e_fault = 1; end
        k++;
      end
      if (e_fault) begin e_owed_v = 1; e_owed_c = chg; return; end
    end
    paid = 0; k = 0;
    while (paid < chg && !e_fault) begin
      tries = 0; ok = 0;
      while (!ok && !e_fault) begin
        e_coin++;
        if (k < cp.size() && cp[k] > 0) ok = 1;
        else begin tries++; if (tries == R) e_fault = 1; end
        k++;
      end
      if (ok) paid++;
    end
    if (e_fault) e_owed_c = chg - paid;
  endtask

  task automatic send_req(input bit v, input logic [1:0] c);
    int i;
    i = 0;
    @(negedge clk);
    while (!ifc.req_ready && i < 100) begin @(negedge clk); i++; end
    ifc.req_valid = 1; ifc.req_vend = v; ifc.req_change = c;
    @(posedge clk); #1 ifc.req_valid = 0;
  endtask

  task automatic wait_end(output bit to);
    to = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done || fault) begin to = 0; break; end
    end
  endtask

  task automatic test_reset();
    rst = 0; fault_clr = 0; spur_coin = 0;
    ifc.req_valid = 0; ifc.req_vend = 0; ifc.req_change = 0;
    repeat (3) @(negedge clk);
    n_chk++; if (ifc.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", ifc.req_ready); end
    n_chk++; if ({prod_release, coin_eject, done, fault, vend_owed, coins_owed} !== 7'b0) begin
      n_err++; $display("FAIL reset_outs got=%b%b%b%b%b%b exp=0", prod_release, coin_eject, done, fault, vend_owed, coins_owed); end
    rst = 1;
    repeat (2) @(negedge clk);
    fault_clr = 1; @(negedge clk); fault_clr = 0; @(negedge clk);
    n_chk++; if (ifc.req_ready !== 1'b1 || fault !== 1'b0) begin
      n_err++; $display("FAIL clr_in_idle ready=%b fault=%b exp 1/0", ifc.req_ready, fault); end
  endtask

  task automatic test_full();
    int p0, c0, d0, g0, l0; bit to;
    prod_plan = '{10}; coin_plan = '{10, 10, 10};
    p0 = n_prod; c0 = n_coin; d0 = n_done; g0 = gap_len.size(); l0 = coin_len.size();
    send_req(1, 2'b11);
    wait_end(to);
    repeat (3) @(negedge clk);
    n_chk++; if (to) begin n_err++; $display("FAIL full_timeout no done/fault"); end
    n_chk++; if (n_prod - p0 != 1) begin n_err++; $display("FAIL full_prod got=%0d exp=1", n_prod - p0); end
    n_chk++; if (n_coin - c0 != 3) begin n_err++; $display("FAIL full_coin got=%0d exp=3", n_coin - c0); end
    n_chk++; if (n_done - d0 != 1) begin n_err++; $display("FAIL full_done got=%0d exp=1", n_done - d0); end
    n_chk++; if (fault !== 1'b0) begin n_err++; $display("FAIL full_fault got=%b exp=0", fault); end
    n_chk++; if (gap_len.size() - g0 != 3) begin n_err++; $display("FAIL full_ngap got=%0d exp=3", gap_len.size() - g0); end
    for (int i = g0; i < gap_len.size(); i++) begin
      n_chk++; if (gap_len[i] != G) begin n_err++; $display("FAIL full_gap%0d got=%0d exp=%0d", i, gap_len[i], G); end
    end
    for (int i = l0; i < coin_len.size(); i++) begin
      n_chk++; if (coin_len[i] >= T) begin n_err++; $display("FAIL full_coinlen got=%0d exp<%0d", coin_len[i], T); end
    end
  endtask

  task automatic test_empty();
    int p0, c0;
    p0 = n_prod; c0 = n_coin;
    send_req(0, 2'b00);
    @(negedge clk);
    n_chk++; if (done !== 1'b1 || ifc.req_ready !== 1'b0) begin
      n_err++; $display("FAIL empty_done1 done=%b ready=%b exp 1/0", done, ifc.req_ready); end
    @(negedge clk);
    n_chk++; if (done !== 1'b0 || ifc.req_ready !== 1'b1) begin
      n_err++; $display("FAIL empty_done2 done=%b ready=%b exp 0/1", done, ifc.req_ready); end
    repeat (3) @(negedge clk);
    n_chk++; if (n_prod != p0 || n_coin != c0) begin
      n_err++; $display("FAIL empty_act prod=%0d coin=%0d exp 0/0", n_prod - p0, n_coin - c0); end
  endtask

  task automatic test_retry();
    int c0, d0, l0; bit to;
    coin_plan = '{0, 7, 7};
    c0 = n_coin; d0 = n_done; l0 = coin_len.size();
    send_req(0, 2'b10);
    wait_end(to);
    repeat (3) @(negedge clk);
    n_chk++; if (to || fault) begin n_err++; $display("FAIL retry_end to=%b fault=%b exp 0/0", to, fault); end
    n_chk++; if (n_coin - c0 != 3) begin n_err++; $display("FAIL retry_coin got=%0d exp=3", n_coin - c0); end
    n_chk++; if (coin_len.size() <= l0 || coin_len[l0] != T) begin
      n_err++; $display("FAIL retry_tlen got=%0d exp=%0d", (coin_len.size() > l0) ? coin_len[l0] : -1, T); end
    n_chk++; if (n_done - d0 != 1) begin n_err++; $display("FAIL retry_done got=%0d exp=1", n_done - d0); end
  endtask

  task automatic test_fault();
    int c0, l0; bit to;
    coin_plan = '{0, 0, 0};
    c0 = n_coin; l0 = coin_len.size();
    send_req(0, 2'b01);
    wait_end(to);
    n_chk++; if (fault !== 1'b1) begin n_err++; $display("FAIL fault_set got=%b exp=1", fault); end
    n_chk++; if (coins_owed !== 2'b01 || vend_owed !== 1'b0) begin
      n_err++; $display("FAIL fault_owed coins=%b vend=%b exp 01/0", coins_owed, vend_owed); end
    n_chk++; if (ifc.req_ready !== 1'b0) begin n_err++; $display("FAIL fault_ready got=%b exp=0", ifc.req_ready); end
    repeat (5) @(negedge clk);
    n_chk++; if (fault !== 1'b1) begin n_err++; $display("FAIL fault_sticky got=%b exp=1", fault); end
    n_chk++; if (n_coin - c0 != 3) begin n_err++; $display("FAIL fault_tries got=%0d exp=3", n_coin - c0); end
    for (int i = l0; i < coin_len.size(); i++) begin
      n_chk++; if (coin_len[i] != T) begin n_err++; $display("FAIL fault_len got=%0d exp=%0d", coin_len[i], T); end
    end
    fault_clr = 1; @(posedge clk); #1 fault_clr = 0;
    @(negedge clk);
    n_chk++; if (fault !== 1'b0 || ifc.req_ready !== 1'b1 || coins_owed !== 2'b00) begin
      n_err++; $display("FAIL fault_clr fault=%b ready=%b owed=%b exp 0/1/00", fault, ifc.req_ready, coins_owed); end
  endtask

  task automatic test_reset_mid();
    int d0, i;
    coin_plan = '{20, 20};
    send_req(0, 2'b10);
    i = 0;
    while (!coin_eject && i < 50) begin @(negedge clk); i++; end
    repeat (3) @(negedge clk);
    n_chk++; if (coin_eject !== 1'b1) begin n_err++; $display("FAIL rmid_pre got=%b exp=1", coin_eject); end
    rst = 0; #1;
    n_chk++; if (coin_eject !== 1'b0) begin n_err++; $display("FAIL rmid_drop got=%b exp=0", coin_eject); end
    repeat (3) @(negedge clk);
    rst = 1;
    d0 = n_done;
    repeat (30) @(negedge clk);
    n_chk++; if (n_done != d0 || ifc.req_ready !== 1'b1 || coin_eject !== 1'b0) begin
      n_err++; $display("FAIL rmid_after done=%0d ready=%b eject=%b exp 0/1/0", n_done - d0, ifc.req_ready, coin_eject); end
    coin_plan.delete();
  endtask

  task automatic test_spurious();
    int p0, c0, d0, a0, i; bit to;
    spur_coin = 1; @(negedge clk); spur_coin = 0;
    repeat (8) @(negedge clk);
    coin_plan = '{5, 5, 5};
    p0 = n_prod; c0 = n_coin; d0 = n_done; a0 = n_acc;
    send_req(0, 2'b11);
    i = 0;
    while (!coin_eject && i < 50) begin @(negedge clk); i++; end
    ifc.req_valid = 1; ifc.req_vend = 1; ifc.req_change = 2'b11;
    repeat (5) @(negedge clk);
    ifc.req_valid = 0;
    i = 0;
    while (coin_eject && i < 100) begin @(negedge clk); i++; end
    spur_coin = 1; @(negedge clk); spur_coin = 0;
    wait_end(to);
    repeat (20) @(negedge clk);
    n_chk++; if (to || fault) begin n_err++; $display("FAIL spur_end to=%b fault=%b exp 0/0", to, fault); end
    n_chk++; if (n_coin - c0 != 3 || n_prod != p0) begin
      n_err++; $display("FAIL spur_count coin=%0d prod=%0d exp 3/0", n_coin - c0, n_prod - p0); end
    n_chk++; if (n_acc - a0 != 1) begin n_err++; $display("FAIL spur_accept got=%0d exp=1", n_acc - a0); end
    n_chk++; if (n_done - d0 != 1) begin n_err++; $display("FAIL spur_done got=%0d exp=1", n_done - d0); end
  endtask

  task automatic test_random();
    int pp[$], cp[$];
    int e_prod, e_coin, e_oc, p0, c0, d0, chg;
    bit e_f, e_ov, vend, to;
    for (int n = 0; n < 16; n++) begin
      vend = 1'($urandom_range(0, 1));
      chg  = $urandom_range(0, 3);
      pp.delete(); cp.delete();
      for (int it = 0; it < int'(vend) + chg; it++)
        for (int t = 0; t < R; t++) begin
          if ($urandom_range(0, 3) == 0) begin
            if (it == 0 && vend) pp.push_back(0); else cp.push_back(0);
          end else begin
            if (it == 0 && vend) pp.push_back($urandom_range(1, 15)); else cp.push_back($urandom_range(1, 15));
            break;
          end
        end
      model(vend, chg, pp, cp, e_prod, e_coin, e_f, e_oc, e_ov);
      prod_plan = pp; coin_plan = cp;
      p0 = n_prod; c0 = n_coin; d0 = n_done;
      send_req(vend, 2'(chg));
      wait_end(to);
      repeat (3) @(negedge clk);
      n_chk++; if (to) begin n_err++; $display("FAIL rnd%0d_timeout", n); end
      n_chk++; if (n_prod - p0 != e_prod || n_coin - c0 != e_coin) begin
        n_err++; $display("FAIL rnd%0d_acts prod=%0d coin=%0d exp %0d/%0d", n, n_prod - p0, n_coin - c0, e_prod, e_coin); end
      n_chk++; if (fault !== e_f || n_done - d0 != int'(!e_f)) begin
        n_err++; $display("FAIL rnd%0d_end fault=%b done=%0d exp %b/%0d", n, fault, n_done - d0, e_f, int'(!e_f)); end
      if (e_f) begin
        n_chk++; if (coins_owed !== 2'(e_oc) || vend_owed !== e_ov) begin
          n_err++; $display("FAIL rnd%0d_owed coins=%0d vend=%b exp %0d/%b", n, coins_owed, vend_owed, e_oc, e_ov); end
        fault_clr = 1; @(posedge clk); #1 fault_clr = 0;
      end
      prod_plan.delete(); coin_plan.delete();
      repeat ($urandom_range(1, 6)) @(negedge clk);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full();
    test_empty();
    test_retry();
    test_fault();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
